pong_control: RTL and testbench

//  Pong game sequencer: one-hot Mealy FSM that serves the ball, moves it left/right,

---
 rtl/pong_control.sv | 107 ++++++++++
 tb/tb_pong_control.sv | 97 +++++++++
 2 files changed

// File: rtl/pong_control.sv
// Pong game sequencer: one-hot Mealy FSM that serves the ball, moves it
// left/right, judges paddle hits and misses, and ends the game.
module pong_control (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       OVER,
  input  logic       START,
  input  logic       DIR,
  input  logic       TICK,
  input  logic       ATL,
  input  logic       ATR,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic [5:0] state,
  output logic       LD,
  output logic       SHL,
  output logic       SHR,
  output logic       CLRPT,
  output logic       PTL,
  output logic       PTR,
  output logic       MAXTIME,
  output logic       SETTIME
);

  typedef enum logic [5:0] {
    INIT   = 6'h01,
    MOVE_R = 6'h02,
    END_R  = 6'h04,
    MOVE_L = 6'h08,
    END_L  = 6'h10,
    DONE   = 6'h20
  } state_e;

  // Register kept as raw bits so non-one-hot codes stay representable and
  // fall through to the recovery branch.
  logic [5:0] state_q;
  logic [5:0] state_d;

  // State register with synchronous reset to INIT.
  always_ff @(posedge CLK) begin
    if (CLR) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next-state and Mealy outputs; first matching transition wins.
  always_comb begin
    state_d = state_q;
    LD      = 1'b0;
    SHL     = 1'b0;
    SHR     = 1'b0;
    CLRPT   = 1'b0;
    PTL     = 1'b0;
    PTR     = 1'b0;
    MAXTIME = 1'b0;
    SETTIME = 1'b0;
    case (state_q)
      INIT: begin
        MAXTIME = 1'b1;
        CLRPT   = 1'b1;
        LD      = START;
        if (START) state_d = DIR ? MOVE_R : MOVE_L;
      end
      DONE: begin
        MAXTIME = 1'b1;
        LD      = START;
        CLRPT   = START;
        if (START) state_d = DIR ? MOVE_R : MOVE_L;
      end
      MOVE_L: begin
        SHL = TICK & ~ATL;
        PTR = BtnL;
        if (OVER)     state_d = DONE;
        else if (ATL) state_d = END_L;
      end
      MOVE_R: begin
        SHR = TICK & ~ATR;
        PTL = BtnR;
        if (OVER)     state_d = DONE;
        else if (ATR) state_d = END_R;
      end
      END_L: begin
        if (BtnL) begin
          SETTIME = 1'b1;
        end else if (TICK) begin
          MAXTIME = 1'b1;
          PTR     = 1'b1;
        end
        if (OVER)             state_d = DONE;
        else if (BtnL | TICK) state_d = MOVE_R;
      end
      END_R: begin
        if (BtnR) begin
          SETTIME = 1'b1;
        end else if (TICK) begin
          MAXTIME = 1'b1;
          PTL     = 1'b1;
        end
        if (OVER)             state_d = DONE;
        else if (BtnR | TICK) state_d = MOVE_L;
      end
      default: state_d = INIT;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_pong_control.sv
// Directed self-checking bench for pong_control.
module tb_pong_control;

  logic       CLK = 1'b0;
  logic       CLR, OVER, START, DIR, TICK, ATL, ATR, BtnL, BtnR;
  logic [5:0] state;
  logic       LD, SHL, SHR, CLRPT, PTL, PTR, MAXTIME, SETTIME;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  // Output bit values in the packed vector below.
  localparam logic [7:0] O_LD = 8'h80, O_SHL = 8'h40, O_SHR = 8'h20,
                         O_CLRPT = 8'h10, O_PTL = 8'h08, O_PTR = 8'h04,
                         O_MAX = 8'h02, O_SET = 8'h01;

  pong_control dut (
    .CLK(CLK), .CLR(CLR), .OVER(OVER), .START(START), .DIR(DIR),
    .TICK(TICK), .ATL(ATL), .ATR(ATR), .BtnL(BtnL), .BtnR(BtnR),
    .state(state), .LD(LD), .SHL(SHL), .SHR(SHR), .CLRPT(CLRPT),
    .PTL(PTL), .PTR(PTR), .MAXTIME(MAXTIME), .SETTIME(SETTIME)
  );

  always #5 CLK = ~CLK;

  assign outs = {LD, SHL, SHR, CLRPT, PTL, PTR, MAXTIME, SETTIME};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic clr, input logic over, input logic start,
                        input logic dir, input logic tick, input logic atl,
                        input logic atr, input logic bl, input logic br);
    CLR = clr; OVER = over; START = start; DIR = dir; TICK = tick;
    ATL = atl; ATR = atr; BtnL = bl; BtnR = br;
  endtask

  // Inputs already applied at the falling edge: check outputs, then next state.
  task automatic cycle(input string tag, input logic [7:0] eo, input logic [5:0] es);
    #1;
    check({tag, ".out"}, outs, eo);
    @(posedge CLK);
    #1;
    check({tag, ".st"}, {2'b00, state}, {2'b00, es});
    @(negedge CLK);
  endtask

  initial begin
    //      clr ovr st dir tk atl atr bl br
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("reset_st", {2'b00, state}, 8'h01);

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("init_idle", O_MAX | O_CLRPT, 6'h01);
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("serve_l", O_LD | O_CLRPT | O_MAX, 6'h08);
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle("movel_tick", O_SHL, 6'h08);
    set_in(0, 0, 0, 0, 1, 1, 0, 0, 0); cycle("movel_atl_tick", 8'h00, 6'h10);
    set_in(0, 0, 0, 0, 1, 0, 0, 1, 0); cycle("endl_hit_tick", O_SET, 6'h02);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("mover_atr", 8'h00, 6'h04);
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle("endr_miss", O_MAX | O_PTL, 6'h08);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); cycle("movel_fault", O_PTR, 6'h08);
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); cycle("movel_over", 8'h00, 6'h20);
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); cycle("done_idle", O_MAX, 6'h20);
    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0); cycle("serve_r", O_LD | O_CLRPT | O_MAX, 6'h02);
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle("mover_tick", O_SHR, 6'h02);
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 1); cycle("mover_fault", O_SHR | O_PTL, 6'h02);
    set_in(0, 0, 0, 0, 1, 0, 1, 0, 0); cycle("mover_atr_tick", 8'h00, 6'h04);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("endr_hold", 8'h00, 6'h04);
    set_in(0, 1, 0, 0, 1, 0, 0, 0, 1); cycle("endr_hit_over", O_SET, 6'h20);
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("done_serve_l", O_LD | O_CLRPT | O_MAX, 6'h08);
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); cycle("movel_atl", 8'h00, 6'h10);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("endl_hold", 8'h00, 6'h10);
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); cycle("endl_miss", O_MAX | O_PTR, 6'h02);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("mover_clr", 8'h00, 6'h01);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("init_after_clr", O_MAX | O_CLRPT, 6'h01);

    // Illegal non-one-hot code must recover to INIT after one edge.
    force dut.state_q = 6'h03;
    #1;
    release dut.state_q;
    check("illegal.out", outs, 8'h00);
    @(posedge CLK);
    #1;
    check("illegal.st", {2'b00, state}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
